mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Pipelined, multi-cycle word memory. It is the responding end of the CPU's load/store and instruction-fetch request interface.
- Accepts at most one read or write request per cycle and returns an in-order response exactly LATENCY cycles later. Backpressure from the requester freezes the pipeline.
- Replaces single-cycle memory instances once the CPU gains stall handling. The instruction and data ports each get their own instance.

Parameters:
- LATENCY, 4: cycles from request acceptance to response visibility; legal range 1..8.
- ADDR_W, 16: byte-address width.
- DEPTH_W, 15: log2 of the number of 16-bit words stored. Must satisfy DEPTH_W <= ADDR_W-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  responder can accept a request this cycle.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; bit 0 must be 0.
- req_wdata  in  16  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester consumes the response this cycle.
- rsp_rdata  out  16  read data; 0 for writes and errors.
- rsp_wr  out  1  echo of req_wr for this response.
- rsp_err  out  1  request was misaligned or out of range.
- busy  out  1  any request in flight; feeds the CPU stall logic.

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline-stage valid bits, rsp_valid, rsp_wr, rsp_err and busy go to 0; rsp_rdata goes to 16'h0000. Array contents are NOT cleared; they persist across reset. Outputs hold these values while rst_n is low.
- Acceptance: a request is accepted on a rising edge when req_valid && req_ready.
  - req_ready = !(rsp_valid && !rsp_ready), i.e. combinational, true unless the output stage is stalled.
  - Accepting a request during the stall cycle is forbidden.
- Word index is req_addr[DEPTH_W:1].
- Error condition: req_addr[0]==1, or any req_addr bit above DEPTH_W is nonzero.
- Array access happens on the acceptance edge:
  - Write: the word is updated unless the request is in error. An errored write leaves the array unchanged.
  - Read: data is sampled from the array contents before any same-edge update. Only one request is accepted per edge, so no same-edge conflict exists.
- Pipeline: a LATENCY-deep shift chain carries {valid, wr, err, rdata}. With no stall, a request accepted at edge k appears on the rsp_* outputs after edge k+LATENCY-1.
- Stall: while rsp_valid && !rsp_ready, every stage holds its value and no new request enters. The chain advances on the first edge where rsp_ready=1 or rsp_valid=0 (bubble collapse is not required; whole-chain freeze).
- Ordering:
  - Responses are strictly in acceptance order.
  - Read-after-write to the same word returns the new data even when the write is still in flight, because the array is written at acceptance.
- Response stage: when it holds no valid entry, rsp_valid=0 and rsp_rdata=0.
- busy = OR of all stage valid bits.
- Throughput: LATENCY outstanding requests maximum. Back-to-back acceptance yields rsp_valid high for consecutive cycles.
- Reset mid-operation: all in-flight requests are discarded with no responses. A write already accepted remains committed in the array.
- LATENCY=1: a request accepted at edge k is visible immediately after edge k.

Test Plan:
- Write 0xBEEF at addr 0x0010, then read 0x0010 the next cycle (LATENCY=4). Required: write response rsp_wr=1, rsp_err=0. Read response 1 cycle later has rsp_rdata=0xBEEF, exactly 4 cycles after its acceptance.
- Stream 6 back-to-back reads of 0x0000..0x000A with rsp_ready=1 after preloading values 1..6. Required: rsp_valid high for 6 consecutive cycles, data 1..6 in order, req_ready constantly 1.
- Drop rsp_ready for 3 cycles while 4 reads are in flight. Required: rsp_valid and rsp_rdata held stable, req_ready=0 during those 3 cycles, no response lost or duplicated, order preserved after release.
- Read 0x0003 (misaligned), and with DEPTH_W=8 write 0x1234 to 0x0400. Required: both responses rsp_err=1, rsp_rdata=0. A read of the aliasing in-range word 0x0000 is unchanged.
- Pull rst_n low mid-cycle with 3 requests in flight, one of them a write of 0x5A5A to 0x0020. Required: rsp_valid and busy drop to 0 immediately and asynchronously; no responses after release; a later read of 0x0020 returns 0x5A5A.
- LATENCY=1 build: write then read of the same word on consecutive cycles. Required: each response appears the cycle after acceptance, and the read returns the written data.

Source files
------------

// File: rtl/mem_responder.sv
// Pipelined word memory answering CPU load/store and fetch requests.
// Fixed-latency in-order responses; requester backpressure freezes the chain.
module mem_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16,
  parameter int DEPTH_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_wr,
  output logic              rsp_err,
  output logic              busy
);

  typedef struct packed {
    logic        vld;
    logic        wr;
    logic        err;
    logic [15:0] dat;
  } stage_t;

  localparam int WORDS = 1 << DEPTH_W;
  localparam logic [ADDR_W-1:0] HI_MASK =
    {ADDR_W{1'b1}} << (DEPTH_W + 1);

  logic [15:0]        mem_q [WORDS];
  stage_t [LATENCY-1:0] stg_q;
  stage_t [LATENCY-1:0] stg_d;
  stage_t             head;
  logic               stall;
  logic               accept;
  logic               req_err;
  logic [DEPTH_W-1:0] idx;

  assign idx     = req_addr[DEPTH_W:1];
  assign req_err = req_addr[0] | (|(req_addr & HI_MASK));

  assign stall     = stg_q[LATENCY-1].vld & ~rsp_ready;
  assign req_ready = ~stall;
  assign accept    = req_valid & req_ready;

  // Reads see the array before this edge's write; only one access per edge.
  always_comb begin
    head.vld = accept;
    head.wr  = accept & req_wr;
    head.err = accept & req_err;
    head.dat = '0;
    if (accept & ~req_wr & ~req_err)
      head.dat = mem_q[idx];
  end

  always_comb begin
    stg_d = stg_q;
    if (!stall) begin
      stg_d[0] = head;
      for (int i = 1; i < LATENCY; i++)
        stg_d[i] = stg_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stg_q <= '0;
    else
      stg_q <= stg_d;
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (accept & req_wr & ~req_err)
      mem_q[idx] <= req_wdata;
  end

  assign rsp_valid = stg_q[LATENCY-1].vld;
  assign rsp_wr    = stg_q[LATENCY-1].wr;
  assign rsp_err   = stg_q[LATENCY-1].err;
  assign rsp_rdata = stg_q[LATENCY-1].dat;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++)
      busy = busy | stg_q[i].vld;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: LATENCY=4/DEPTH_W=8 main
// instance plus a LATENCY=1 instance for the single-cycle case.
module tb_mem_responder;

  localparam int LAT = 4;
  localparam int NW  = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_wr;
  logic        rsp_err;
  logic        busy;

  logic        b_req_valid = 1'b0;
  logic        b_req_wr = 1'b0;
  logic [15:0] b_req_addr = '0;
  logic [15:0] b_req_wdata = '0;
  logic        b_rsp_ready = 1'b1;
  logic        b_req_ready;
  logic        b_rsp_valid;
  logic [15:0] b_rsp_rdata;
  logic        b_rsp_wr;
  logic        b_rsp_err;
  logic        b_busy;

  mem_responder #(.LATENCY(LAT), .ADDR_W(16), .DEPTH_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_wr(rsp_wr), .rsp_err(rsp_err),
    .busy(busy)
  );

  mem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_wr(b_req_wr), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_wr(b_rsp_wr), .rsp_err(b_rsp_err),
    .busy(b_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        err;
    logic [15:0] rd;
    int          acc;
    int          stl;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [15:0] mdl [NW];
  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int stall_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: word memory of NW entries, addresses beyond it are errors.
  function automatic void model_push(input logic wr, input logic [15:0] a,
                                     input logic [15:0] wd);
    exp_t e;
    int   w;
    e.err = a[0] || (int'(a) >= 2 * NW);
    w     = (int'(a) / 2) % NW;
    e.wr  = wr;
    e.rd  = (wr || e.err) ? 16'h0 : mdl[w];
    if (wr && !e.err) mdl[w] = wd;
    e.acc = edge_cnt + 1;
    e.stl = stall_cnt;
    q.push_back(e);
  endfunction

  task automatic drive(input logic v, input logic wr, input logic [15:0] a,
                       input logic [15:0] wd, input logic rdy,
                       output logic acc);
    @(negedge clk);
    #1;
    req_valid = v;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = wd;
    rsp_ready = rdy;
    #1;
    acc = v && req_ready;
    if (acc) model_push(wr, a, wd);
  endtask

  task automatic idle(input logic rdy);
    logic acc;
    drive(1'b0, 1'b0, 16'h0, 16'h0, rdy, acc);
  endtask

  task automatic issue(input logic wr, input logic [15:0] a,
                       input logic [15:0] wd);
    logic acc;
    int   n;
    n = 0;
    do begin
      drive(1'b1, wr, a, wd, 1'b1, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) fail_now("issue_timeout");
  endtask

  // Monitor: samples just before each rising edge.
  initial begin : mon
    logic prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        chk("req_ready", req_ready, !(rsp_valid && !rsp_ready));
        chk("busy", busy,
            rsp_valid || (q.size() > 0 && q[0].acc <= edge_cnt));
        if (rsp_valid && !prev_stall) begin
          if (q.size() == 0) begin
            fail_now("unexpected_response");
          end else begin
            cur = q.pop_front();
            chk("rsp_rdata", rsp_rdata, cur.rd);
            chk("rsp_wr", rsp_wr, cur.wr);
            chk("rsp_err", rsp_err, cur.err);
            chk("latency", edge_cnt,
                cur.acc + LAT - 1 + stall_cnt - cur.stl);
          end
        end else if (rsp_valid) begin
          chk("hold_rdata", rsp_rdata, cur.rd);
          chk("hold_wr", rsp_wr, cur.wr);
          chk("hold_err", rsp_err, cur.err);
        end else begin
          chk("idle_rdata", rsp_rdata, 16'h0);
          chk("idle_wr", rsp_wr, 1'b0);
          chk("idle_err", rsp_err, 1'b0);
        end
        prev_stall = rsp_valid && !rsp_ready;
        if (prev_stall) stall_cnt++;
      end
    end
  end

  initial begin : main
    logic        acc;
    logic        v;
    logic        wr;
    logic        rdy;
    logic [15:0] a;
    int          n;
    int          m;

    repeat (2) @(negedge clk);
    #3;
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rsp_rdata, 16'h0);
    chk("rst_wr", rsp_wr, 1'b0);
    chk("rst_err", rsp_err, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_b_valid", b_rsp_valid, 1'b0);
    chk("rst_b_busy", b_busy, 1'b0);
    #4;
    rst_n = 1'b1;

    for (int w = 0; w < NW; w++)
      issue(1'b1, 16'(2 * w), (w < 6) ? 16'(w + 1) : 16'($urandom));

    issue(1'b1, 16'h0010, 16'hBEEF);
    issue(1'b0, 16'h0010, 16'h0);

    for (int i = 0; i < 6; i++)
      issue(1'b0, 16'(2 * i), 16'h0);

    for (int i = 0; i < 4; i++)
      issue(1'b0, 16'(2 * i), 16'h0);
    n = 0;
    do begin
      idle(1'b1);
      n++;
    end while (!rsp_valid && n < 20);
    if (!rsp_valid) fail_now("stall_wait_timeout");
    repeat (3) begin
      drive(1'b1, 1'b1, 16'h0030, 16'hDEAD, 1'b0, acc);
      chk("stall_req_ready", req_ready, 1'b0);
    end
    idle(1'b1);

    issue(1'b0, 16'h0003, 16'h0);
    issue(1'b1, 16'h0400, 16'h1234);
    issue(1'b0, 16'h0000, 16'h0);

    repeat (400) begin
      v   = ($urandom % 4) != 0;
      rdy = ($urandom % 4) != 0;
      wr  = ($urandom % 2) != 0;
      m   = $urandom % 10;
      if (m == 0)     a = 16'($urandom) | 16'h1;
      else if (m == 1) a = 16'(512 + 2 * ($urandom % 32000));
      else if (m < 6) a = 16'(2 * ($urandom % 16));
      else            a = 16'(2 * ($urandom % NW));
      drive(v, wr, a, 16'($urandom), rdy, acc);
    end
    idle(1'b1);
    issue(1'b0, 16'h0030, 16'h0);

    n = 0;
    while (q.size() > 0 && n < 100) begin
      idle(1'b1);
      n++;
    end
    if (q.size() != 0) fail_now("drain_timeout");

    issue(1'b1, 16'h0020, 16'h5A5A);
    issue(1'b0, 16'h0010, 16'h0);
    issue(1'b0, 16'h0012, 16'h0);
    idle(1'b1);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_rst_valid", rsp_valid, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    #7;
    rst_n = 1'b1;
    repeat (6) idle(1'b1);
    issue(1'b0, 16'h0020, 16'h0);
    n = 0;
    while (q.size() > 0 && n < 100) begin
      idle(1'b1);
      n++;
    end
    if (q.size() != 0) fail_now("drain2_timeout");
    repeat (2) idle(1'b1);

    @(negedge clk);
    #1;
    b_req_valid = 1'b1;
    b_req_wr    = 1'b1;
    b_req_addr  = 16'h0042;
    b_req_wdata = 16'hCAFE;
    #1;
    chk("b_req_ready", b_req_ready, 1'b1);
    @(negedge clk);
    #1;
    b_req_wr = 1'b0;
    #2;
    chk("b_wr_valid", b_rsp_valid, 1'b1);
    chk("b_wr_wr", b_rsp_wr, 1'b1);
    chk("b_wr_err", b_rsp_err, 1'b0);
    chk("b_wr_rdata", b_rsp_rdata, 16'h0);
    @(negedge clk);
    #1;
    b_req_valid = 1'b0;
    #2;
    chk("b_rd_valid", b_rsp_valid, 1'b1);
    chk("b_rd_wr", b_rsp_wr, 1'b0);
    chk("b_rd_err", b_rsp_err, 1'b0);
    chk("b_rd_rdata", b_rsp_rdata, 16'hCAFE);
    @(negedge clk);
    #3;
    chk("b_idle_valid", b_rsp_valid, 1'b0);
    chk("b_idle_busy", b_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
